controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  clock; all state changes occur on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a computation, level-sampled.
- lt  in  1  loop-terminate status from the datapath; 1 means the iteration limit has been reached.
- initt  out  1  clear or initialise the term register T.
- initr  out  1  clear or initialise the result register R.
- initc  out  1  clear the iteration counter.
- ready  out  1  controller is idle and can accept start.
- ld_c  out  1  load the coefficient register C.
- ld_x  out  1  load the input register X.
- ld_r  out  1  load the result register R.
- ld_t  out  1  load the term register T.
- cnt  out  1  increment the iteration counter.
- s2  out  1  datapath mux select, bit 2 (one-hot with s1 and s0).
- s1  out  1  datapath mux select, bit 1.
- s0  out  1  datapath mux select, bit 0.
- mode  out  1  ALU mode; 0 means multiply, 1 means multiply-accumulate.

Function
REQ-002 The block SHALL be a Moore FSM: every output is decoded from the current state only.
REQ-003 Every output not listed for a state SHALL be 0 in that state.
REQ-004 The FSM SHALL have these states, each producing the listed outputs:
- IDLE: ready=1.
- WAIT_REL: no outputs asserted.
- INIT: initt=1, initr=1, initc=1, ld_x=1.
- MUL: s0=1, mode=0, ld_t=1. Meaning: T <= T*X.
- COEF: s1=1, ld_c=1. Meaning: C <= coefficient[counter].
- MAC: s2=1, mode=1, ld_r=1. Meaning: R <= R + T*C.
- CHECK: cnt=1.
REQ-005 The FSM SHALL take these transitions:
- IDLE: start=1 -> WAIT_REL; otherwise stay in IDLE.
- WAIT_REL: start=0 -> INIT; otherwise stay in WAIT_REL.
- INIT -> MUL, unconditionally.
- MUL -> COEF, unconditionally.
- COEF -> MAC, unconditionally.
- MAC -> CHECK, unconditionally.
- CHECK: lt=1 -> IDLE; lt=0 -> MUL.
REQ-006 One loop iteration (MUL, COEF, MAC, CHECK) SHALL take exactly 4 cycles.
REQ-007 cnt SHALL be asserted in every CHECK cycle regardless of lt, so the final iteration is also counted.
REQ-008 lt SHALL be sampled only in CHECK; lt is ignored in all other states.
REQ-009 start SHALL be ignored outside IDLE and WAIT_REL; a new computation can begin only after returning to IDLE.
REQ-010 If start is held high, the FSM SHALL stay in WAIT_REL, with no datapath activity, until start falls.
REQ-011 The latency from the first rising edge that samples start=0 in WAIT_REL to the INIT cycle SHALL be 1 cycle.
REQ-012 At most one of s2, s1, s0 SHALL be high in any cycle.
REQ-013 ready SHALL be high if and only if the state is IDLE.
REQ-014 The state register SHALL be 3 bits wide, and the unused encoding SHALL transition to IDLE on the next edge.
REQ-015 The block SHALL contain no datapath arithmetic; it only issues control strobes.

Reset
REQ-016 When rst=1 at a rising edge, the state SHALL become IDLE, overriding any transition.
REQ-017 After that edge, outputs SHALL be ready=1 and all other outputs 0.
REQ-018 Reset SHALL take effect from any state, including mid-loop, with no residual strobes on the following cycle.
REQ-019 At power-up without reset, the state register SHALL initialise to IDLE (simulation initial value).

Verification
REQ-020 The bench SHALL cover these scenarios:
- Idle hold: rst pulse, start=0 for 5 cycles -> ready=1 and all other outputs 0 throughout.
- Start handshake: start=1 for 1 cycle, then 0 -> WAIT_REL for 1 cycle, then INIT with initt=initr=initc=ld_x=1 for exactly 1 cycle, then MUL with s0=1 and ld_t=1.
- Loop: lt=0 for 10 cycles after INIT -> repeating strobe pattern ld_t, ld_c, ld_r, cnt with period 4; s0, s1, s2 track the MUL, COEF and MAC states; mode=1 only in MAC.
- Termination: lt=1 raised mid-iteration -> the FSM finishes the current iteration, asserts cnt once in CHECK, and has ready=1 on the next cycle; lt=1 during MUL, COEF or MAC causes no early exit.
- Held start: start=1 for 4 cycles -> no INIT until the cycle after start falls; ready=0 while held.
- Reset mid-loop: rst=1 during MAC -> ready=1 and all strobes 0 the next cycle; a subsequent start/release runs a normal INIT.

Source files
------------

// File: rtl/controller.sv
// Moore sequencer for an iterative multiply / multiply-accumulate datapath.
// It drives the init, load, count and mux-select strobes from the current state and does no arithmetic itself.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready=1; waits for start
// WAIT_REL | start seen; waits for start to be released
// INIT     | clear T, R and the counter; load X
// MUL      | T <= T*X (s0, ld_t, mode=0)
// COEF     | C <= coefficient[counter] (s1, ld_c)
// MAC      | R <= R + T*C (s2, ld_r, mode=1)
// CHECK    | increment the counter; leave when lt=1
module controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lt,
  output logic initt,
  output logic initr,
  output logic initc,
  output logic ready,
  output logic ld_c,
  output logic ld_x,
  output logic ld_r,
  output logic ld_t,
  output logic cnt,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic mode
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_REL = 3'd1;
  localparam logic [2:0] INIT     = 3'd2;
  localparam logic [2:0] MUL      = 3'd3;
  localparam logic [2:0] COEF     = 3'd4;
  localparam logic [2:0] MAC      = 3'd5;
  localparam logic [2:0] CHECK    = 3'd6;

  // The initialiser gives a defined IDLE state at power-up even without a reset.
  logic [2:0] state = IDLE;
  logic [2:0] state_nxt;

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = start ? WAIT_REL : IDLE;
      WAIT_REL: state_nxt = start ? WAIT_REL : INIT;
      INIT:     state_nxt = MUL;
      MUL:      state_nxt = COEF;
      COEF:     state_nxt = MAC;
      MAC:      state_nxt = CHECK;
      CHECK:    state_nxt = lt ? IDLE : MUL;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    initt = 1'b0;
    initr = 1'b0;
    initc = 1'b0;
    ready = 1'b0;
    ld_c  = 1'b0;
    ld_x  = 1'b0;
    ld_r  = 1'b0;
    ld_t  = 1'b0;
    cnt   = 1'b0;
    s2    = 1'b0;
    s1    = 1'b0;
    s0    = 1'b0;
    mode  = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      INIT: begin
        initt = 1'b1;
        initr = 1'b1;
        initc = 1'b1;
        ld_x  = 1'b1;
      end
      MUL: begin
        s0   = 1'b1;
        ld_t = 1'b1;
      end
      COEF: begin
        s1   = 1'b1;
        ld_c = 1'b1;
      end
      MAC: begin
        s2   = 1'b1;
        mode = 1'b1;
        ld_r = 1'b1;
      end
      CHECK: cnt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: a vector table walks the FSM through its scenarios,
// then hand sequences cover power-up state and a counted multi-iteration run.
module tb_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic lt = 1'b0;
  logic initt, initr, initc, ready, ld_c, ld_x, ld_r, ld_t, cnt, s2, s1, s0, mode;

  int checks = 0;
  int fails  = 0;

  controller dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt),
    .initt(initt), .initr(initr), .initc(initc), .ready(ready),
    .ld_c(ld_c), .ld_x(ld_x), .ld_r(ld_r), .ld_t(ld_t), .cnt(cnt),
    .s2(s2), .s1(s1), .s0(s0), .mode(mode)
  );

  always #5 clk = ~clk;

  // Packed order: initt initr initc ready ld_c ld_x ld_r ld_t cnt s2 s1 s0 mode
  localparam logic [12:0] E_IDLE  = 13'b0001_0000_0000_0;
  localparam logic [12:0] E_WAIT  = 13'b0000_0000_0000_0;
  localparam logic [12:0] E_INIT  = 13'b1110_0100_0000_0;
  localparam logic [12:0] E_MUL   = 13'b0000_0001_0001_0;
  localparam logic [12:0] E_COEF  = 13'b0000_1000_0010_0;
  localparam logic [12:0] E_MAC   = 13'b0000_0010_0100_1;
  localparam logic [12:0] E_CHECK = 13'b0000_0000_1000_0;

  typedef struct {
    logic        rst;
    logic        start;
    logic        lt;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] outs();
    return {initt, initr, initc, ready, ld_c, ld_x, ld_r, ld_t, cnt, s2, s1, s0, mode};
  endfunction

  task automatic add(input logic r, input logic s, input logic l, input logic [12:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.lt = l; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic s, input logic l);
    @(negedge clk);
    rst = r; start = s; lt = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt_seen;
    int cycles;

    // Power-up: no reset yet, state must already be IDLE.
    #1;
    check("powerup", outs(), E_IDLE);

    // Idle hold
    add(1, 0, 0, E_IDLE);
    for (int i = 0; i < 5; i++) add(0, 0, 0, E_IDLE);
    // Start handshake
    add(0, 1, 0, E_WAIT);
    add(0, 0, 0, E_INIT);
    // 10 loop cycles with lt=0; start pulses inside the loop are ignored
    add(0, 0, 0, E_MUL);
    add(0, 0, 0, E_COEF);
    add(0, 1, 0, E_MAC);
    add(0, 0, 0, E_CHECK);
    add(0, 0, 0, E_MUL);
    add(0, 0, 0, E_COEF);
    add(0, 0, 0, E_MAC);
    add(0, 1, 0, E_CHECK);
    add(0, 0, 0, E_MUL);
    add(0, 0, 0, E_COEF);
    // lt raised mid-iteration: finish MAC, CHECK, then IDLE
    add(0, 0, 1, E_MAC);
    add(0, 0, 1, E_CHECK);
    add(0, 0, 1, E_IDLE);
    // Held start: 4 cycles in WAIT_REL
    add(0, 1, 0, E_WAIT);
    add(0, 1, 0, E_WAIT);
    add(0, 1, 0, E_WAIT);
    add(0, 1, 0, E_WAIT);
    add(0, 0, 0, E_INIT);
    // lt high through MUL/COEF/MAC: no early exit
    add(0, 0, 1, E_MUL);
    add(0, 0, 1, E_COEF);
    add(0, 0, 1, E_MAC);
    // Reset during MAC, then a normal restart
    add(1, 0, 0, E_IDLE);
    add(0, 0, 0, E_IDLE);
    add(0, 1, 0, E_WAIT);
    add(0, 0, 0, E_INIT);
    add(0, 0, 0, E_MUL);
    add(0, 0, 0, E_COEF);
    // Reset overrides a pending start in WAIT_REL
    add(1, 1, 0, E_IDLE);
    add(0, 1, 0, E_WAIT);
    add(1, 0, 0, E_IDLE);
    add(0, 0, 0, E_IDLE);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].lt);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      checks++;
      if ($countones({s2, s1, s0}) > 1) begin
        fails++;
        $display("FAIL onehot vec%0d: got s2s1s0=%b required at most one high", i, {s2, s1, s0});
      end
    end

    // Counted run: lt rises only once three CHECK cycles have been seen.
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check("run_init", outs(), E_INIT);
    cnt_seen = 0;
    cycles   = 0;
    while (!ready && cycles < 100) begin
      step(0, 0, (cnt_seen >= 3));
      cycles++;
      if (cnt) cnt_seen++;
    end
    check_int("run_ready_timeout", int'(ready), 1);
    check_int("run_cnt_pulses", cnt_seen, 3);
    check_int("run_cycles", cycles, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
